// File: rtl/bram_access_ctrl_pkg.sv
// Shared definitions for the table-BRAM access controller: FSM states and
// the grant-vector bit positions used by the arbiter and the top level.
package bram_access_ctrl_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int GNT0 = 0;
    localparam int GNT1 = 1;

endpackage

// File: rtl/bram_access_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from req; the
// last-grant register flips priority after each grant when advance is high.
module rr_arb2
    import bram_access_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 1 = requester 1 won last, so requester 0 wins the next contention
    logic last_grant;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (advance && (gnt != 2'b00)) begin
            last_grant <= gnt[GNT1];
        end
    end

endmodule

// File: rtl/bram_access_ctrl.sv
// Arbitrates two requesters onto one single-port table BRAM and provides a
// full-memory clear sweep. Read data comes straight from the BRAM output.
module bram_access_ctrl
    import bram_access_ctrl_pkg::*;
#(
    parameter int            n         = 13,
    parameter int            w         = 16,
    parameter logic [w-1:0]  CLEAR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic         req0_write,
    input  logic [n-1:0] req0_addr,
    input  logic [w-1:0] req0_wdata,
    output logic         req0_ready,
    output logic         req0_rvalid,
    input  logic         req1_valid,
    input  logic         req1_write,
    input  logic [n-1:0] req1_addr,
    input  logic [w-1:0] req1_wdata,
    output logic         req1_ready,
    output logic         req1_rvalid,
    output logic [w-1:0] rdata,
    input  logic         clear_start,
    output logic         clear_busy,
    output logic         clear_done,
    output logic [n-1:0] mem_addr,
    output logic         mem_read_write,
    output logic [w-1:0] mem_data_in,
    input  logic [w-1:0] mem_data_out
);

    state_t       state_q, state_d;
    logic [n-1:0] clr_cnt_q, clr_cnt_d;
    logic         clr_done_q, clr_done_d;
    logic         run_en;
    logic         clr_term;
    logic [1:0]   arb_req;
    logic [1:0]   gnt;
    logic [1:0]   vld_p1;
    logic [n-1:0] addr_hold_p1;

    // A clear request or reset blocks all grants in the cycle it is seen
    assign run_en   = rst_n && (state_q == ST_RUN) && !clear_start;
    assign arb_req  = {req1_valid, req0_valid} & {2{run_en}};
    assign clr_term = (clr_cnt_q == {n{1'b1}});

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (arb_req),
        .advance (run_en),
        .gnt     (gnt)
    );

    always_comb begin
        state_d        = state_q;
        clr_cnt_d      = clr_cnt_q;
        clr_done_d     = 1'b0;
        mem_addr       = addr_hold_p1;
        mem_read_write = 1'b0;
        mem_data_in    = '0;
        case (state_q)
            ST_RUN: begin
                if (clear_start) begin
                    state_d = ST_CLEAR;
                end
                if (gnt[GNT0]) begin
                    mem_addr       = req0_addr;
                    mem_read_write = req0_write;
                    mem_data_in    = req0_wdata;
                end else if (gnt[GNT1]) begin
                    mem_addr       = req1_addr;
                    mem_read_write = req1_write;
                    mem_data_in    = req1_wdata;
                end
            end
            ST_CLEAR: begin
                mem_addr       = clr_cnt_q;
                mem_read_write = 1'b1;
                mem_data_in    = CLEAR_VAL;
                if (clr_term) begin
                    state_d    = ST_RUN;
                    clr_cnt_d  = '0;
                    clr_done_d = 1'b1;
                end else begin
                    clr_cnt_d  = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (!rst_n) begin
            mem_read_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            clr_cnt_q  <= '0;
            clr_done_q <= 1'b0;
            vld_p1     <= 2'b00;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_done_q <= clr_done_d;
            vld_p1     <= {gnt[GNT1] & ~req1_write, gnt[GNT0] & ~req0_write};
        end
    end

    // p0 -> p1: address hold; rvalid tag above lines up with the BRAM output
    always_ff @(posedge clk) begin
        addr_hold_p1 <= mem_addr;
    end

    assign req0_ready  = gnt[GNT0];
    assign req1_ready  = gnt[GNT1];
    assign req0_rvalid = vld_p1[GNT0] & rst_n;
    assign req1_rvalid = vld_p1[GNT1] & rst_n;
    assign rdata       = mem_data_out;
    assign clear_busy  = (state_q == ST_CLEAR) & rst_n;
    assign clear_done  = clr_done_q & rst_n;

endmodule

// File: tb/tb_bram_access_ctrl.sv
// Bench for bram_access_ctrl with a 16-entry BRAM model; directed scenarios
// followed by randomized traffic, all checked against a transaction-level model.
module tb_bram_access_ctrl;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int DEPTH = 16;
    localparam logic [W-1:0] CLR = 16'h0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req0_write = 1'b0;
    logic [N-1:0] req0_addr = '0;
    logic [W-1:0] req0_wdata = '0;
    logic         req1_valid = 1'b0, req1_write = 1'b0;
    logic [N-1:0] req1_addr = '0;
    logic [W-1:0] req1_wdata = '0;
    logic         clear_start = 1'b0;
    logic         req0_ready, req0_rvalid, req1_ready, req1_rvalid;
    logic [W-1:0] rdata;
    logic         clear_busy, clear_done;
    logic [N-1:0] mem_addr;
    logic         mem_read_write;
    logic [W-1:0] mem_data_in;
    logic [W-1:0] mem_data_out;

    logic [W-1:0] bram [DEPTH];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_data_out <= bram[mem_addr];
        if (mem_read_write) bram[mem_addr] <= mem_data_in;
    end

    bram_access_ctrl #(.n(N), .w(W), .CLEAR_VAL(CLR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
        .rdata(rdata), .clear_start(clear_start), .clear_busy(clear_busy),
        .clear_done(clear_done), .mem_addr(mem_addr), .mem_read_write(mem_read_write),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    // Reference model state
    logic [W-1:0] ref_mem [DEPTH];
    bit           ref_clearing, ref_done, ref_last, ref_addr_known;
    int           ref_idx, ref_pend, gnt_prev;
    logic [W-1:0] ref_pend_data;
    logic [N-1:0] ref_addr;
    int           vec_cnt, err_cnt, done_seen, busy_seen;
    logic         done_rdy0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        int           g;
        logic [N-1:0] ga;
        bit           gw;
        logic [W-1:0] wd;
        @(negedge clk);
        g = -1; ga = '0; gw = 1'b0; wd = '0;
        if (!rst_n) begin
            chk("rst_rdy0", req0_ready, 0);
            chk("rst_rdy1", req1_ready, 0);
            chk("rst_rv0", req0_rvalid, 0);
            chk("rst_rv1", req1_rvalid, 0);
            chk("rst_busy", clear_busy, 0);
            chk("rst_done", clear_done, 0);
            chk("rst_mrw", mem_read_write, 0);
        end else if (ref_clearing) begin
            chk("clr_rdy0", req0_ready, 0);
            chk("clr_rdy1", req1_ready, 0);
            chk("clr_busy", clear_busy, 1);
            chk("clr_done", clear_done, 0);
            chk("clr_mrw", mem_read_write, 1);
            chk("clr_addr", mem_addr, ref_idx);
            chk("clr_din", mem_data_in, CLR);
        end else begin
            if (!clear_start) begin
                if (req0_valid && req1_valid) g = ref_last ? 0 : 1;
                else if (req0_valid) g = 0;
                else if (req1_valid) g = 1;
            end
            chk("rdy0", req0_ready, g == 0);
            chk("rdy1", req1_ready, g == 1);
            chk("busy", clear_busy, 0);
            chk("done", clear_done, ref_done);
            if (g >= 0) begin
                ga = (g == 0) ? req0_addr : req1_addr;
                gw = (g == 0) ? req0_write : req1_write;
                wd = (g == 0) ? req0_wdata : req1_wdata;
                chk("maddr", mem_addr, ga);
                chk("mrw", mem_read_write, gw);
                if (gw) chk("mdin", mem_data_in, wd);
            end else begin
                chk("idle_mrw", mem_read_write, 0);
                chk("idle_mdin", mem_data_in, 0);
                if (ref_addr_known) chk("hold_addr", mem_addr, ref_addr);
            end
        end
        if (rst_n) begin
            chk("rv0", req0_rvalid, ref_pend == 0);
            chk("rv1", req1_rvalid, ref_pend == 1);
            if (ref_pend >= 0) chk("rdata", rdata, ref_pend_data);
        end
        if (clear_done) begin
            done_seen++;
            done_rdy0 = req0_ready;
        end
        if (clear_busy) busy_seen++;
        // advance the model across the coming edge
        if (!rst_n) begin
            ref_clearing = 0; ref_done = 0; ref_last = 1; ref_pend = -1; ref_addr_known = 0;
        end else if (ref_clearing) begin
            ref_mem[ref_idx] = CLR;
            ref_addr = N'(ref_idx);
            ref_addr_known = 1;
            ref_pend = -1;
            ref_idx++;
            if (ref_idx == DEPTH) begin
                ref_clearing = 0;
                ref_done = 1;
            end
        end else begin
            ref_done = 0;
            ref_pend = -1;
            if (clear_start) begin
                ref_clearing = 1;
                ref_idx = 0;
            end else if (g >= 0) begin
                ref_last = (g == 1);
                ref_addr = ga;
                ref_addr_known = 1;
                if (gw) ref_mem[ga] = wd;
                else begin
                    ref_pend = g;
                    ref_pend_data = ref_mem[ga];
                end
            end
        end
        gnt_prev = g;
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic wr, input int a, input logic [W-1:0] d);
        req0_valid = v; req0_write = wr; req0_addr = N'(a); req0_wdata = d;
    endtask

    task automatic set1(input logic v, input logic wr, input int a, input logic [W-1:0] d);
        req1_valid = v; req1_write = wr; req1_addr = N'(a); req1_wdata = d;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_cnt = 0; err_cnt = 0; done_seen = 0; busy_seen = 0; done_rdy0 = 1'b0;
        ref_clearing = 0; ref_done = 0; ref_last = 1; ref_pend = -1;
        ref_addr_known = 0; ref_idx = 0; gnt_prev = -1; ref_addr = '0; ref_pend_data = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;

        // single requester write then read
        set0(1, 1, 3, 16'hA5A5); step();
        set0(1, 0, 3, 16'h0000); step();
        set0(0, 0, 0, 16'h0000); step();

        // contention on reads, after seeding addresses 1 and 2
        set0(1, 1, 1, 16'h1111); step();
        set0(0, 0, 0, 0); set1(1, 1, 2, 16'h2222); step();
        set1(0, 0, 0, 0); step();
        set0(1, 0, 1, 0); set1(1, 0, 2, 0);
        repeat (4) step();
        set0(0, 0, 0, 0); set1(0, 0, 0, 0); step();

        // write from req1 followed immediately by read from req0
        set1(1, 1, 5, 16'h1234); step();
        set1(0, 0, 0, 0); set0(1, 0, 5, 0); step();
        set0(0, 0, 0, 0); step();

        // fill, then clear while req0 waits
        for (int i = 0; i < DEPTH; i++) begin
            set0(1, 1, i, W'($urandom)); step();
        end
        done_seen = 0; busy_seen = 0; done_rdy0 = 1'b0;
        set0(1, 0, 0, 0); clear_start = 1'b1; step();
        clear_start = 1'b0;
        repeat (17) step();
        set0(0, 0, 0, 0); step();
        chk("clr1_done_cnt", done_seen, 1);
        chk("clr1_busy_cnt", busy_seen, 16);
        chk("clr1_done_gnt", done_rdy0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            set0(1, 0, i, 0); step();
        end
        set0(0, 0, 0, 0); step();

        // second clear_start mid-sweep is ignored
        done_seen = 0; busy_seen = 0;
        clear_start = 1'b1; step();
        clear_start = 1'b0; repeat (4) step();
        clear_start = 1'b1; step();
        clear_start = 1'b0; repeat (16) step();
        chk("clr2_done_cnt", done_seen, 1);
        chk("clr2_busy_cnt", busy_seen, 16);

        // reset in the middle of a sweep
        for (int i = 0; i < DEPTH; i++) begin
            set1(1, 1, i, W'($urandom)); step();
        end
        set1(0, 0, 0, 0); step();
        done_seen = 0; busy_seen = 0;
        clear_start = 1'b1; step();
        clear_start = 1'b0; repeat (7) step();
        rst_n = 1'b0; set0(1, 0, 4, 0); set1(1, 0, 9, 0); step();
        rst_n = 1'b1; repeat (4) step();
        chk("rst_mid_done_cnt", done_seen, 0);
        chk("rst_mid_busy_cnt", busy_seen, 7);
        set0(0, 0, 0, 0); set1(0, 0, 0, 0); step();

        // randomized traffic with rare clears and resets
        for (int c = 0; c < 500; c++) begin
            if (!(req0_valid && gnt_prev != 0))
                set0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, DEPTH - 1)), W'($urandom));
            if (!(req1_valid && gnt_prev != 1))
                set1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, DEPTH - 1)), W'($urandom));
            clear_start = ($urandom_range(0, 59) == 0);
            rst_n = ($urandom_range(0, 149) != 0);
            step();
        end
        clear_start = 1'b0; rst_n = 1'b1;
        set0(0, 0, 0, 0); set1(0, 0, 0, 0);
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
